// File: rtl/bsg_mesh_link_pipe.sv
// Multi-link elastic pipe between two mesh tiles: one FIFO per direction
// per link, with stubbing, freeze/drain, idle flag and flit counters.
module bsg_mesh_link_pipe #(
  parameter int width_p = 256,
  parameter int num_links_p = 4,
  parameter int depth_p = 2,
  parameter logic [num_links_p-1:0] stub_p = '0,
  parameter int counter_width_p = 32
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic [num_links_p*(width_p+2)-1:0] link_a_i,
  output logic [num_links_p*(width_p+2)-1:0] link_a_o,
  input  logic [num_links_p*(width_p+2)-1:0] link_b_i,
  output logic [num_links_p*(width_p+2)-1:0] link_b_o,
  input  logic freeze_i,
  input  logic clear_ctr_i,
  output logic idle_o,
  output logic [2*num_links_p*counter_width_p-1:0] ctr_o
);

  localparam int lw = width_p + 2;
  localparam int nc = 2 * num_links_p;
  localparam int aw = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam int cw = $clog2(depth_p + 1);

  logic [nc-1:0] in_v;
  logic [nc-1:0] ds_rdy;
  logic [nc-1:0] enq_rdy;
  logic [nc-1:0] deq_v;
  logic [nc-1:0] ch_empty;
  logic [width_p-1:0] in_data [nc];
  logic [width_p-1:0] deq_data [nc];

  function automatic logic [aw-1:0] bump(input logic [aw-1:0] p);
    return (p == aw'(depth_p - 1)) ? '0 : p + aw'(1);
  endfunction

  for (genvar l = 0; l < num_links_p; l++) begin : g_link
    assign in_v[2*l]      = link_a_i[l*lw+lw-1];
    assign in_data[2*l]   = link_a_i[l*lw +: width_p];
    assign ds_rdy[2*l]    = link_b_i[l*lw+width_p];
    assign in_v[2*l+1]    = link_b_i[l*lw+lw-1];
    assign in_data[2*l+1] = link_b_i[l*lw +: width_p];
    assign ds_rdy[2*l+1]  = link_a_i[l*lw+width_p];

    assign link_a_o[l*lw +: lw] =
      {deq_v[2*l+1], enq_rdy[2*l], deq_data[2*l+1]};
    assign link_b_o[l*lw +: lw] =
      {deq_v[2*l], enq_rdy[2*l+1], deq_data[2*l]};

    for (genvar d = 0; d < 2; d++) begin : g_dir
      localparam int c = 2*l + d;

      if (stub_p[l]) begin : g_stub
        logic unused_stub;
        assign unused_stub = ^{in_v[c], ds_rdy[c], in_data[c]};
        assign enq_rdy[c]  = 1'b1;
        assign deq_v[c]    = 1'b0;
        assign deq_data[c] = '0;
        assign ch_empty[c] = 1'b1;
        assign ctr_o[c*counter_width_p +: counter_width_p] = '0;
      end else begin : g_fifo
        logic [width_p-1:0] mem [depth_p];
        logic [aw-1:0] rptr;
        logic [aw-1:0] wptr;
        logic [cw-1:0] cnt;
        logic [counter_width_p-1:0] ctr;
        logic full;
        logic enq;
        logic deq;

        // ready looks only at the registered count, never at ds_rdy
        assign full        = (cnt == cw'(depth_p));
        assign enq_rdy[c]  = ~full & ~freeze_i & reset_n_i;
        assign deq_v[c]    = (cnt != '0) & reset_n_i;
        assign deq_data[c] = mem[rptr];
        assign ch_empty[c] = (cnt == '0);
        assign enq         = in_v[c] & enq_rdy[c];
        assign deq         = deq_v[c] & ds_rdy[c];

        always_ff @(posedge clk_i) begin
          if (enq) mem[wptr] <= in_data[c];
        end

        always_ff @(posedge clk_i) begin
          if (!reset_n_i) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
          end else begin
            if (enq) wptr <= bump(wptr);
            if (deq) rptr <= bump(rptr);
            cnt <= cnt + cw'(enq) - cw'(deq);
          end
        end

        always_ff @(posedge clk_i) begin
          if (!reset_n_i)
            ctr <= '0;
          else if (clear_ctr_i)
            ctr <= '0;
          else if (deq && !(&ctr))
            ctr <= ctr + counter_width_p'(1);
        end

        assign ctr_o[c*counter_width_p +: counter_width_p] = ctr;
      end
    end
  end

  assign idle_o = &ch_empty;

endmodule

// File: tb/tb_bsg_mesh_link_pipe.sv
// Bench for bsg_mesh_link_pipe: randomized traffic on two configurations,
// checked against per-channel flit queues and counter model.
module tb_bsg_mesh_link_pipe;

  localparam int W = 16;
  localparam int LW = W + 2;
  localparam int NL = 4;
  localparam int NC = 10;
  localparam int CW0 = 32;
  localparam int CW1 = 4;
  localparam logic [NL-1:0] STUB = 4'b0010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic freeze = 1'b0;
  logic clr = 1'b0;

  logic [NL*LW-1:0] a0_i, b0_i, a0_o, b0_o;
  logic [LW-1:0] a1_i, b1_i, a1_o, b1_o;
  logic idle0, idle1;
  logic [2*NL*CW0-1:0] ctr0;
  logic [2*CW1-1:0] ctr1;

  logic i_v [NC];
  logic i_dsr [NC];
  logic [W-1:0] i_data [NC];
  logic o_v [NC];
  logic o_rdy [NC];
  logic [W-1:0] o_data [NC];
  logic [31:0] o_ctr [NC];

  logic [W-1:0] q [NC][$];
  logic [31:0] mctr [NC];
  bit exp_rdy [NC];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bsg_mesh_link_pipe #(
    .width_p(W), .num_links_p(NL), .depth_p(2),
    .stub_p(STUB), .counter_width_p(CW0)
  ) dut0 (
    .clk_i(clk), .reset_n_i(rst_n),
    .link_a_i(a0_i), .link_a_o(a0_o),
    .link_b_i(b0_i), .link_b_o(b0_o),
    .freeze_i(freeze), .clear_ctr_i(clr),
    .idle_o(idle0), .ctr_o(ctr0)
  );

  bsg_mesh_link_pipe #(
    .width_p(W), .num_links_p(1), .depth_p(3),
    .stub_p(1'b0), .counter_width_p(CW1)
  ) dut1 (
    .clk_i(clk), .reset_n_i(rst_n),
    .link_a_i(a1_i), .link_a_o(a1_o),
    .link_b_i(b1_i), .link_b_o(b1_o),
    .freeze_i(freeze), .clear_ctr_i(clr),
    .idle_o(idle1), .ctr_o(ctr1)
  );

  always_comb begin
    for (int l = 0; l < NL; l++) begin
      a0_i[l*LW +: LW] = {i_v[2*l], i_dsr[2*l+1], i_data[2*l]};
      b0_i[l*LW +: LW] = {i_v[2*l+1], i_dsr[2*l], i_data[2*l+1]};
    end
    a1_i = {i_v[8], i_dsr[9], i_data[8]};
    b1_i = {i_v[9], i_dsr[8], i_data[9]};
  end

  always_comb begin
    for (int l = 0; l < NL; l++) begin
      o_rdy[2*l]    = a0_o[l*LW+W];
      o_v[2*l]      = b0_o[l*LW+LW-1];
      o_data[2*l]   = b0_o[l*LW +: W];
      o_rdy[2*l+1]  = b0_o[l*LW+W];
      o_v[2*l+1]    = a0_o[l*LW+LW-1];
      o_data[2*l+1] = a0_o[l*LW +: W];
    end
    for (int c = 0; c < 8; c++) o_ctr[c] = ctr0[c*CW0 +: CW0];
    o_rdy[8]  = a1_o[W];
    o_v[8]    = b1_o[LW-1];
    o_data[8] = b1_o[W-1:0];
    o_rdy[9]  = b1_o[W];
    o_v[9]    = a1_o[LW-1];
    o_data[9] = a1_o[W-1:0];
    o_ctr[8]  = {28'b0, ctr1[3:0]};
    o_ctr[9]  = {28'b0, ctr1[7:4]};
  end

  function automatic int depth_of(input int c);
    return (c < 8) ? 2 : 3;
  endfunction

  function automatic bit stub_of(input int c);
    return (c < 8) ? STUB[c/2] : 1'b0;
  endfunction

  function automatic logic [31:0] cmax_of(input int c);
    return (c < 8) ? 32'hFFFF_FFFF : 32'h0000_000F;
  endfunction

  task automatic chk(input string name, input int c,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d t=%0t: got %0h expected %0h",
               name, c, $time, act, exp);
    end
  endtask

  // Scoreboard push: a flit is owed downstream once the model says the
  // channel had room while the source offered it.
  always @(posedge clk) begin
    for (int c = 0; c < NC; c++)
      if (i_v[c] && exp_rdy[c] && !stub_of(c))
        q[c].push_back(i_data[c]);
  end

  // Monitor: compares the DUT against the queue model, then advances the
  // model for the edge about to happen.
  always @(negedge clk) begin : mon
    bit e0, e1, ev, er;
    e0 = 1'b1;
    e1 = 1'b1;
    for (int c = 0; c < NC; c++)
      if (!stub_of(c) && q[c].size() != 0) begin
        if (c < 8) e0 = 1'b0;
        else e1 = 1'b0;
      end
    chk("idle", 0, idle0, e0);
    chk("idle", 8, idle1, e1);
    for (int c = 0; c < NC; c++) begin
      ev = !stub_of(c) && rst_n && q[c].size() > 0;
      er = stub_of(c) ? 1'b1
         : (rst_n && !freeze && q[c].size() < depth_of(c));
      exp_rdy[c] = er;
      chk("ready", c, o_rdy[c], er);
      chk("valid", c, o_v[c], ev);
      chk("ctr", c, o_ctr[c], mctr[c]);
      if (stub_of(c)) chk("stub_data", c, o_data[c], 0);
      if (ev && i_dsr[c]) begin
        chk("data", c, o_data[c], q[c][0]);
        void'(q[c].pop_front());
        if (mctr[c] != cmax_of(c)) mctr[c] = mctr[c] + 1;
      end
      if (!rst_n) begin
        q[c].delete();
        mctr[c] = 0;
      end else if (clr) begin
        mctr[c] = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    for (int c = 0; c < NC; c++) begin
      i_v[c] = 1'b0;
      i_dsr[c] = 1'b0;
      i_data[c] = '0;
      mctr[c] = 0;
      exp_rdy[c] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;
    tick;

    // single flit, one-cycle latency, no bypass
    for (int c = 0; c < NC; c++) i_dsr[c] = 1'b1;
    i_v[0] = 1'b1;
    i_data[0] = 16'h00A5;
    #1;
    chk("t1_no_bypass", 0, o_v[0], 0);
    tick;
    i_v[0] = 1'b0;
    chk("t1_v", 0, o_v[0], 1);
    chk("t1_data", 0, o_data[0], 32'h00A5);
    repeat (3) tick;
    chk("t1_ctr", 0, o_ctr[0], 1);
    chk("t1_idle", 0, idle0, 1);

    // streaming on every channel
    clr = 1'b1;
    tick;
    clr = 1'b0;
    for (int n = 0; n < 100; n++) begin
      for (int c = 0; c < NC; c++) begin
        i_v[c] = 1'b1;
        i_data[c] = W'($urandom);
      end
      tick;
    end
    for (int c = 0; c < NC; c++) i_v[c] = 1'b0;
    repeat (4) tick;
    for (int c = 0; c < NC; c++)
      chk("t2_ctr", c, o_ctr[c], stub_of(c) ? 0 : (c < 8 ? 100 : 15));

    // backpressure on link 2 A->B
    i_dsr[4] = 1'b0;
    i_v[4] = 1'b1;
    repeat (4) begin
      i_data[4] = W'($urandom);
      tick;
    end
    chk("t3_full", 4, o_rdy[4], 0);
    i_dsr[4] = 1'b1;
    #1;
    chk("t3_full_deq", 4, o_rdy[4], 0);
    tick;
    i_dsr[4] = 1'b0;
    chk("t3_freed", 4, o_rdy[4], 1);
    i_data[4] = W'($urandom);
    tick;
    i_v[4] = 1'b0;
    i_dsr[4] = 1'b1;
    repeat (4) tick;
    chk("t3_ctr", 4, o_ctr[4], 103);

    // freeze with two flits buffered on link 0 A->B
    i_dsr[0] = 1'b0;
    i_v[0] = 1'b1;
    repeat (2) begin
      i_data[0] = W'($urandom);
      tick;
    end
    freeze = 1'b1;
    #1;
    chk("t4_frz_rdy", 0, o_rdy[0], 0);
    i_dsr[0] = 1'b1;
    k = 0;
    while (!idle0 && k < 20) begin
      tick;
      k++;
    end
    chk("t4_idle", 0, idle0, 1);
    chk("t4_ctr", 0, o_ctr[0], 102);
    repeat (3) tick;
    chk("t4_no_accept", 0, idle0, 1);
    freeze = 1'b0;
    i_v[0] = 1'b0;
    tick;

    // clear concurrent with a handshake on a saturated counter
    i_v[8] = 1'b1;
    i_data[8] = 16'h1234;
    tick;
    i_v[8] = 1'b0;
    clr = 1'b1;
    tick;
    clr = 1'b0;
    chk("t6_clr", 8, o_ctr[8], 0);

    // reset with one flit buffered
    i_dsr[8] = 1'b0;
    i_v[8] = 1'b1;
    tick;
    i_v[8] = 1'b0;
    chk("t6_buffered", 8, o_v[8], 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_v", 8, o_v[8], 0);
    chk("t6_rst_rdy", 8, o_rdy[8], 0);
    tick;
    rst_n = 1'b1;
    #1;
    chk("t6_post_v", 8, o_v[8], 0);
    chk("t6_post_rdy", 8, o_rdy[8], 1);
    chk("t6_post_idle", 8, idle1, 1);
    i_dsr[8] = 1'b1;
    repeat (3) tick;
    chk("t6_post_ctr", 8, o_ctr[8], 0);

    // random traffic with occasional freeze, clear and reset
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NC; c++) begin
        i_v[c] = ($urandom_range(0, 3) != 0);
        i_dsr[c] = ($urandom_range(0, 2) != 0);
        i_data[c] = W'($urandom);
      end
      freeze = ($urandom_range(0, 15) == 0);
      clr = ($urandom_range(0, 63) == 0);
      rst_n = ($urandom_range(0, 255) != 0);
      tick;
    end
    rst_n = 1'b1;
    freeze = 1'b0;
    clr = 1'b0;
    for (int c = 0; c < NC; c++) begin
      i_v[c] = 1'b0;
      i_dsr[c] = 1'b1;
    end
    repeat (10) tick;
    chk("final_idle", 0, idle0, 1);
    chk("final_idle", 8, idle1, 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
